// File: rtl/sram_23k640_responder.sv
// sram_23k640_responder: SPI mode-0 target modelling a 23K640 SRAM (READ/WRITE/RDSR/WRSR).
// SPI pins are registered once; edges of the registered sck drive all transfer logic.
module sram_23k640_responder #(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_si,
  output logic              o_so,
  output logic [7:0]        o_status,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_RD, DATA_WR, STAT_RD, STAT_WR, IGNORE} state_t;
  state_t state_q, state_d;
  logic sck_q, sckp_q, cs_q, si_q;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-2:0] sin_q, sin_d;
  logic [7:0] sout_q, sout_d, st_q, st_d, wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wa_q, wa_d, ain, addr_nx;
  logic rd_q, rd_d, so_q, so_d, wr_q, wr_d;
  logic rise, fall, byte_rx, byte_tx, sh_out, page, seq, mem_we;
  logic [7:0] bin;
  logic [7:0] mem [2**ADDR_W];
  assign rise = sck_q & ~sckp_q;
  assign fall = ~sck_q & sckp_q;
  assign ain = {sin_q, si_q};
  assign bin = ain[7:0];
  assign byte_rx = rise && cnt_q[2:0] == 3'd7;
  assign byte_tx = fall && cnt_q[2:0] == 3'd7;
  assign sh_out = state_q == DATA_RD || state_q == STAT_RD;
  assign page = st_q[7:6] == 2'b10;
  assign seq = st_q[7:6] == 2'b01;
  assign addr_nx = page ? {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)} : addr_q + ADDR_W'(1);
  assign mem_we = !cs_q && state_q == DATA_WR && byte_rx;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (cs_q) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (byte_rx) state_d = (bin == 8'h03 || bin == 8'h02) ? ADDR : bin == 8'h05 ? STAT_RD : bin == 8'h01 ? STAT_WR : IGNORE;
        ADDR:    if (rise && cnt_q == 4'd15) state_d = rd_q ? DATA_RD : DATA_WR;
        DATA_RD: if (byte_tx && !(page || seq)) state_d = IGNORE;
        DATA_WR: if (byte_rx && !(page || seq)) state_d = IGNORE;
        STAT_WR: if (byte_rx) state_d = IGNORE;
        default: ;
      endcase
  end
  always_comb begin
    cnt_d = cnt_q;
    sin_d = sin_q;
    sout_d = sout_q;
    addr_d = addr_q;
    rd_d = rd_q;
    so_d = so_q;
    wr_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    st_d = st_q;
    if (cs_q) begin
      cnt_d = '0;
      so_d = 1'b0;
    end else begin
      if (rise && !sh_out) begin
        sin_d = ain[ADDR_W-2:0];
        cnt_d = cnt_q + 4'd1;
      end
      if (fall) so_d = sh_out & sout_q[7];
      if (fall && sh_out) begin
        sout_d = {sout_q[6:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      case (state_q)
        CMD: if (byte_rx) begin
          cnt_d = '0;
          rd_d = bin == 8'h03;
          sout_d = st_q;
        end
        ADDR: if (rise && cnt_q == 4'd15) begin
          cnt_d = '0;
          addr_d = ain;
          sout_d = mem[ain];
        end
        DATA_RD: if (byte_tx) begin
          addr_d = addr_nx;
          sout_d = mem[addr_nx];
        end
        DATA_WR: if (byte_rx) begin
          wr_d = 1'b1;
          wa_d = addr_q;
          wd_d = bin;
          addr_d = addr_nx;
        end
        STAT_RD: if (byte_tx) sout_d = st_q;
        STAT_WR: if (byte_rx) st_d = {bin[7:6], 5'b0, bin[0]};
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      sck_q <= 1'b0;
      sckp_q <= 1'b0;
      cs_q <= 1'b1;
      si_q <= 1'b0;
      cnt_q <= '0;
      sin_q <= '0;
      sout_q <= '0;
      addr_q <= '0;
      rd_q <= 1'b0;
      so_q <= 1'b0;
      wr_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      st_q <= '0;
    end else begin
      sck_q <= i_sck;
      sckp_q <= sck_q;
      cs_q <= i_cs;
      si_q <= i_si;
      cnt_q <= cnt_d;
      sin_q <= sin_d;
      sout_q <= sout_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      so_q <= so_d;
      wr_q <= wr_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      st_q <= st_d;
    end
  // Array contents deliberately survive reset.
  always_ff @(posedge i_clk)
    if (mem_we) mem[addr_q] <= bin;
  assign o_so = so_q;
  assign o_status = st_q;
  assign o_wr = wr_q;
  assign o_wr_addr = wa_q;
  assign o_wr_data = wd_q;
endmodule

// File: tb/tb_sram_23k640_responder.sv
// tb_sram_23k640_responder: scoreboard bench driving SPI transactions against a byte-array model.
module tb_sram_23k640_responder;
  logic i_clk = 1'b0, i_rst = 1'b1, i_sck = 1'b0, i_cs = 1'b1, i_si = 1'b0;
  logic o_so, o_wr;
  logic [7:0] o_status, o_wr_data;
  logic [12:0] o_wr_addr;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] mdl [8192];
  logic [7:0] st = 8'h00;
  bit ex_chk[$];
  logic [7:0] ex_val[$];
  int wq_a[$];
  logic [7:0] wq_d[$];
  logic [7:0] wbuf[$];

  sram_23k640_responder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sck(i_sck), .i_cs(i_cs), .i_si(i_si),
    .o_so(o_so), .o_status(o_status), .o_wr(o_wr), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit pm();
    return st[7:6] == 2'b10 || st[7:6] == 2'b01;
  endfunction

  function automatic int nxt(input int a);
    if (st[7:6] == 2'b10) return (a & 'h1FE0) | ((a + 1) & 'h1F);
    return (a + 1) & 'h1FFF;
  endfunction

  task automatic sck_bit(input logic b);
    i_si = b;
    repeat (4) @(negedge i_clk);
    i_sck = 1'b1;
    repeat (4) @(negedge i_clk);
    i_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit chk, input logic [7:0] exp);
    ex_chk.push_back(chk);
    ex_val.push_back(exp);
    for (int i = 7; i >= 0; i--) sck_bit(b[i]);
  endtask

  task automatic cs_low;
    @(negedge i_clk);
    i_cs = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic cs_high;
    repeat (4) @(negedge i_clk);
    i_cs = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic cmd_addr(input logic [7:0] c, input logic [15:0] a);
    spi_byte(c, 0, 0);
    spi_byte(a[15:8], 0, 0);
    spi_byte(a[7:0], 0, 0);
  endtask

  task automatic wrsr(input logic [7:0] v);
    cs_low;
    spi_byte(8'h01, 0, 0);
    spi_byte(v, 0, 0);
    cs_high;
    st = {v[7:6], 5'b0, v[0]};
    check("o_status", o_status, st);
  endtask

  task automatic rdsr(input int n);
    cs_low;
    spi_byte(8'h05, 0, 0);
    for (int i = 0; i < n; i++) spi_byte(8'h00, 1, st);
    cs_high;
  endtask

  task automatic do_write(input logic [15:0] a0);
    int a = a0 & 'h1FFF;
    cs_low;
    cmd_addr(8'h02, a0);
    for (int i = 0; i < wbuf.size(); i++) begin
      if (i == 0 || pm()) begin
        wq_a.push_back(a);
        wq_d.push_back(wbuf[i]);
        mdl[a] = wbuf[i];
        a = nxt(a);
      end
      spi_byte(wbuf[i], 0, 0);
    end
    cs_high;
  endtask

  task automatic do_read(input logic [15:0] a0, input int n);
    int a = a0 & 'h1FFF;
    cs_low;
    cmd_addr(8'h03, a0);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, 1, (i == 0 || pm()) ? mdl[a] : 8'h00);
      if (pm()) a = nxt(a);
    end
    cs_high;
  endtask

  // o_so monitor: one byte per 8 sck rises, re-framed on every CS deassert.
  initial begin
    logic [7:0] sh;
    int nb;
    bit c;
    logic [7:0] v;
    nb = 0;
    sh = 8'h00;
    forever begin
      @(posedge i_sck or posedge i_cs);
      if (i_cs) nb = 0;
      else begin
        sh = {sh[6:0], o_so};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (ex_chk.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL so_byte: got %0h with no expectation queued", sh);
          end else begin
            c = ex_chk.pop_front();
            v = ex_val.pop_front();
            if (c) check("so_byte", sh, v);
          end
        end
      end
    end
  end

  always @(negedge i_clk)
    if (o_wr === 1'b1) begin
      if (wq_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, none expected", o_wr_addr, o_wr_data);
      end else begin
        check("wr_addr", o_wr_addr, wq_a.pop_front());
        check("wr_data", o_wr_data, wq_d.pop_front());
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_so", o_so, 0);
    check("rst_status", o_status, 0);
    check("rst_wr", o_wr, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    wrsr(8'h41);
    rdsr(2);
    wrsr(8'hFF);
    rdsr(1);
    wrsr(8'h00);
    wbuf.delete(); wbuf.push_back(8'hA5); wbuf.push_back(8'h5A);
    do_write(16'h0123);
    do_read(16'h0123, 3);
    wrsr(8'h80);
    wbuf.delete(); wbuf.push_back(8'h11); wbuf.push_back(8'h22); wbuf.push_back(8'h33);
    do_write(16'h001F);
    do_read(16'h001F, 3);
    wrsr(8'h40);
    wbuf.delete(); wbuf.push_back(8'hAA); wbuf.push_back(8'hBB);
    do_write(16'h1FFF);
    do_read(16'h1FFF, 2);
    wrsr(8'h00);
    wbuf.delete(); wbuf.push_back(8'h77);
    do_write(16'h0010);
    cs_low;
    cmd_addr(8'h02, 16'h0010);
    for (int i = 0; i < 5; i++) sck_bit(1'b1);
    cs_high;
    check("so_deselected", o_so, 0);
    do_read(16'h0010, 1);
    cs_low;
    spi_byte(8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) spi_byte(8'h00, 1, 8'h00);
    cs_high;
    wrsr(8'h40);
    wbuf.delete(); wbuf.push_back(8'hF0);
    do_write(16'h0200);
    cs_low;
    cmd_addr(8'h03, 16'h0200);
    for (int i = 0; i < 3; i++) sck_bit(1'b0);
    repeat (4) @(negedge i_clk);
    check("so_before_rst", o_so, 1);
    i_rst = 1'b1;
    #1;
    st = 8'h00;
    check("rst_mid_so", o_so, 0);
    check("rst_mid_status", o_status, 0);
    @(negedge i_clk);
    i_cs = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    do_read(16'h0200, 2);
    for (int t = 0; t < 16; t++) begin
      logic [7:0] m;
      logic [15:0] a;
      int n;
      case ($urandom_range(0, 3))
        0: m = 8'h00;
        1: m = 8'h80;
        2: m = 8'h40;
        default: m = 8'hC0;
      endcase
      m[0] = 1'($urandom_range(0, 1));
      wrsr(m);
      a = 16'($urandom_range(0, 65535));
      n = $urandom_range(1, 4);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
      do_write(a);
      do_read(a, pm() ? n : n + 1);
    end
    repeat (10) @(negedge i_clk);
    check("wr_queue_empty", wq_a.size(), 0);
    check("so_queue_empty", ex_chk.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_23k640_responder.md
# sram_23k640_responder

Cycle-accurate SPI responder modelling a Microchip 23K640 SRAM. It is the target-side counterpart to our 23K640 SPI controller and sits on the far side of the o_sck/o_cs/o_so/i_si wires. It lets the controller and any future read path be exercised in simulation and on FPGA loopback without the physical part. It decodes READ, WRITE, RDSR and WRSR, holds an internal byte array and a status register, and supports byte, page and sequential modes.

## Interface
- ADDR_W, 13, array address width; depth 2^ADDR_W bytes (8 KiB default).
- PAGE_W, 5, page address width; page size 2^PAGE_W bytes (32).
- i_clk  in  1  system clock, same domain as the controller's i_clk. Reset i_rst, asynchronous, active-high; clock i_clk.
- i_rst  in  1  asynchronous active-high reset.
- i_sck  in  1  SPI clock from the controller; idles low (mode 0).
- i_cs  in  1  chip select, active-low; high = deselected.
- i_si  in  1  serial data from the controller (controller o_so).
- o_so  out  1  serial data to the controller.
- o_status  out  8  current status register, for observation.
- o_wr  out  1  one-cycle pulse on every array write commit.
- o_wr_addr  out  ADDR_W  address of the committed write.
- o_wr_data  out  8  data of the committed write.

## Operation
- i_sck, i_cs and i_si are registered once into sck_r, cs_r and si_r. sck_p holds the previous sck_r.
- rise = sck_r & ~sck_p. fall = ~sck_r & sck_p.
- Bits are sampled from si_r on rise, MSB first. o_so changes only on fall, or on CS deassert.
- States:
  - IDLE: while cs_r high, bit counter = 0. cs_r low → CMD.
  - CMD: 8 bits. On the 8th rise, branch on the command byte:
    - 0x03 → ADDR (read)
    - 0x02 → ADDR (write)
    - 0x05 → STAT_RD
    - 0x01 → STAT_WR
    - any other value → IGNORE
  - ADDR: 16 bits. Upper 16-ADDR_W bits are discarded. On the 16th rise:
    - read: load the shift register from mem[addr] and go to DATA_RD.
    - write: go to DATA_WR.
  - DATA_RD: on each fall, drive the shift register MSB and shift. After 8 bits, advance the address per mode and reload.
  - DATA_WR: on the 8th rise, commit the byte to mem[addr] and pulse o_wr. Then advance the address per mode.
  - STAT_RD: shift out o_status. It repeats every 8 bits until CS deasserts.
  - STAT_WR: on the 8th rise, status[7:6] ← bits 7:6 and status[0] ← bit 0. Status bits 5:1 always read 0. Further bits are ignored.
  - IGNORE: o_so = 0 and nothing is written until CS deasserts.
- Mode is taken from status[7:6]:
  - 00 byte: after the first data byte, the block moves to IGNORE.
  - 10 page: address low PAGE_W bits increment with wrap; upper bits are held.
  - 01 sequential: the full ADDR_W address increments, and 2^ADDR_W-1 wraps to 0.
  - 11 reserved: treated as byte mode.
- CS deassert (cs_r high) in any state → IDLE on the next cycle.
  - Any partial data byte is discarded with no o_wr pulse.
  - o_so is forced to 0.
- The array is not reset. Initial contents are undefined (X in simulation). The bench must write before reading.

## Timing
- Reset values: o_so=0, o_status=8'h00 (byte mode), o_wr=0, o_wr_addr=0, o_wr_data=0, state IDLE, counters 0.
- Reset asserted mid-transfer aborts it immediately. The status register returns to 0x00; array contents are retained.
- i_sck high and low phases must each be at least 2 i_clk cycles. Narrower pulses give undefined behaviour.
- o_so updates on the i_clk edge after the cycle in which fall is detected. Latency from the i_sck falling edge is 2 i_clk cycles.
- The first read data bit (bit 7) is driven on the fall following the 24th rise, i.e. the rise of the last address bit.
- o_wr is high for exactly one cycle: the cycle after the rise of the 8th data bit is detected. o_wr_addr and o_wr_data are valid in that cycle and hold until the next commit.
- A WRSR commit and a mode change take effect for the next CS-framed transaction only.
- CS falling and a rise in the same registered cycle: that rise is treated as CMD bit 7.

## Test plan
- WRSR 0x01, data 0x41, then RDSR 0x05 → 0x41 shifted out. o_status = 8'h41. Bits 5:1 stay 0 after writing 0xFF (readback 0xC1).
- Byte mode: WRITE 0x02, addr 0x0123, data 0xA5 → one o_wr pulse (addr 0x0123, data 0xA5). A second byte 0x5A is ignored. READ 0x03 0x0123 → 0xA5, then 0x00 on further clocks.
- Page mode (status 0x80): WRITE from 0x001F with 0x11,0x22,0x33 → commits to 0x001F,0x0000,0x0001. READ from 0x001F with 3 bytes → 0x11,0x22,0x33.
- Sequential mode (status 0x40): WRITE 0x1FFF with 0xAA,0xBB → commits to 0x1FFF,0x0000. READ from 0x1FFF → 0xAA,0xBB.
- WRITE 0x02 0x0010, raise CS after 5 data bits → no o_wr pulse. Subsequent READ 0x0010 returns the prior value. o_so = 0 while deselected.
- Command 0xFF followed by 24 clocks → o_so stays 0 and no o_wr. Assert i_rst mid-READ → o_so = 0 and o_status = 0x00 immediately. Array data written before the reset reads back intact.
